// File: rtl/stream_pkg.sv
// Shared types and helpers for stochastic bitstream stages.
// WINDOW(W) also gives the period of a W-bit maximal-length LFSR generator.
package stream_pkg;

    typedef enum logic {IDLE, ACCUM} dec_state_t;

    function automatic int WINDOW(input int w);
        return (2 ** w) - 1;
    endfunction

endpackage

// File: rtl/stream_decoder_window_counter.sv
// Sample counter for one decode window of WINDOW(W) accepted samples.
// last flags the final sample slot; the counter wraps to 0 after it.
module window_counter
    import stream_pkg::*;
#(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [W-1:0] LAST_CNT = W'(WINDOW(W) - 1);

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == LAST_CNT);
    assign last   = w_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_decoder.sv
// Counts ones of a stochastic bitstream over WINDOW(W) samples and
// presents each window result through a one-deep valid/ready register.
module stream_decoder
    import stream_pkg::*;
#(
    parameter int W          = 8,
    parameter bit CONTINUOUS = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         x,
    input  logic         en,
    output logic [W-1:0] y,
    output logic         y_valid,
    input  logic         y_ready,
    output logic         busy,
    output logic         overrun
);

    dec_state_t   r_state;
    logic [W-1:0] r_acc;
    logic [W-1:0] r_y;
    logic         r_y_valid;
    logic         r_overrun;

    logic         w_last;
    logic         w_sample;
    logic         w_done;
    logic         w_free;
    logic [W-1:0] w_final;

    // A start pulse discards the sample of its own cycle.
    assign w_sample = (r_state == ACCUM) && en && !start;
    assign w_done   = w_sample && w_last;
    assign w_free   = !r_y_valid || y_ready;
    assign w_final  = r_acc + W'(x);

    window_counter #(
        .W (W)
    ) u_window_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .en   (w_sample),
        .last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (start) begin
                r_state <= ACCUM;
                r_acc   <= '0;
            end else if (w_sample) begin
                if (w_last) begin
                    r_acc   <= '0;
                    r_state <= (CONTINUOUS != 1'b0) ? ACCUM : IDLE;
                end else begin
                    r_acc <= w_final;
                end
            end

            if (w_done && w_free) begin
                r_y       <= w_final;
                r_y_valid <= 1'b1;
            end else if (r_y_valid && y_ready) begin
                r_y_valid <= 1'b0;
            end

            if (start) begin
                r_overrun <= 1'b0;
            end else if (w_done && !w_free) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign busy    = (r_state == ACCUM);
    assign overrun = r_overrun;

endmodule
